instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch sequencer: the requester side of the instruction-memory fetch protocol. Owns the 8-bit program counter, drives byte address and address strobe into the instruction memory, captures the returned 16-bit instruction, and presents it to decode under a valid/ready handshake. Handles branch redirects from execute and, optionally, stops fetching on HALT.

## Interface
- `RESET_PC`, 8'h00: PC value loaded on reset; bit 0 is ignored and forced to 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `mem_addr` output 8: byte address to instruction memory; always equals `pc`.
- `mem_addr_strobe` output 1: high for exactly one cycle per fetch (the ADDR phase).
- `mem_data` input 16: instruction word from memory, `{byte[a], byte[a+1]}`.
- `instr` output 16: captured instruction.
- `instr_pc` output 8: address the presented `instr` was fetched from.
- `instr_valid` output 1: `instr`/`instr_pc` are valid.
- `instr_ready` input 1: decode accepts when `instr_valid && instr_ready` at a rising edge.
- `redirect` input 1: one-cycle branch/jump request.
- `redirect_pc` input 8: target; bit 0 forced to 0.
- `pc` output 8: address of the current or next fetch.
- `halted` output 1: fetch stopped on HALT (only with the macro defined).

## Operation
- States: ADDR, XFER, CAPT, OUT, HALT.
- ADDR: `mem_addr_strobe`=1. Memory latches the word at this edge. Next state: XFER.
- XFER: strobe=0. Memory moves the word to `mem_data` at this edge. Next state: CAPT.
- CAPT: strobe=0. At the edge, `instr`<=`mem_data`, `instr_pc`<=`pc`, `instr_valid`<=1, `pc`<=`pc`+2. Next state: OUT.
- OUT: hold `instr`/`instr_pc`/`instr_valid` stable until accepted. On accept: `instr_valid`<=0 and go to ADDR, or to HALT (see Configuration).
- PC arithmetic is 8-bit modulo. 8'hFE+2 wraps to 8'h00. Bit 0 of `pc` is always 0.
- Redirect has highest priority in every state:
  - `pc`<=`{redirect_pc[7:1],1'b0}`, `instr_valid`<=0, `halted`<=0, next state ADDR.
  - Any in-flight fetch is abandoned and its data is never presented.
- Redirect in the same cycle as an accept: the accept is counted by decode, and the redirect is still taken.
- `instr_ready` is ignored while `instr_valid`=0.
- Reset mid-operation: asynchronous return to reset values, whatever the state. No partial fetch survives.

## Timing
- Reset values:
  - `pc`=`mem_addr`=`RESET_PC & 8'hFE`
  - `mem_addr_strobe`=0, `instr`=16'h0000, `instr_pc`=8'h00, `instr_valid`=0, `halted`=0
  - state=ADDR, but the strobe is held low while `reset_n`=0.
- The first strobe is the first cycle after `reset_n` deasserts, because memory contents are initialised only during reset.
- Fetch latency: strobe in cycle N, `instr_valid` high in cycle N+3.
- Back-to-back throughput with `instr_ready` tied high: one instruction per 4 cycles. The next strobe is in the cycle after acceptance.
- A redirect sampled in cycle N puts a strobe with the new address in cycle N+1.
- `mem_addr` is stable for the whole ADDR/XFER/CAPT sequence.

## Configuration
- Macro: `INSTR_FETCH_HALT_DETECT_EN`.
- Defined:
  - Acceptance of `instr`==16'h0000 moves to HALT. `halted`<=1 on the same edge.
  - In HALT: no strobes, `instr_valid`=0, `pc` holds the address after the HALT.
  - Only `redirect` or reset leaves HALT.
- Undefined:
  - 16'h0000 is an ordinary instruction and fetch continues sequentially, wrapping at 8'hFE.
  - The HALT state is not built and `halted` is tied to 0.

## Test plan
- Reset release, memory model with 8'h21, 8'hFE at 0..1, `instr_ready`=1 -> strobe in cycle 1 with `mem_addr`=0; cycle 4 `instr`=16'h21FE, `instr_pc`=0, `instr_valid`=1; next strobe at `mem_addr`=2.
- Decode stall: `instr_ready`=0 for 5 cycles while valid -> `instr`, `instr_pc` and `instr_valid` stay constant, no strobe; accept on cycle 6 -> strobe in cycle 7.
- Redirect to 8'h23 during XFER -> the old word is never presented; strobe next cycle with `mem_addr`=8'h22; the word from 0x22 appears 3 cycles later.
- Wrap: `RESET_PC`=8'hFE -> first `instr_pc`=8'hFE, then the next fetch uses `mem_addr`=8'h00.
- With the macro, 16'h0000 at address 62 -> accepted; `halted`=1; no further strobes for 20 cycles; `redirect` to 0 clears `halted` and fetch resumes at 0.
- Reset asserted during OUT with `instr_valid`=1 -> `instr_valid`, `pc`, `halted` and strobe return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory address/data phase signals, the decode
// valid/ready handshake and the execute-stage redirect request.
interface instr_fetch_unit_if;
    logic [7:0]  mem_addr;
    logic        mem_addr_strobe;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    modport master (
        output mem_addr, mem_addr_strobe, instr, instr_pc, instr_valid,
        input  mem_data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_addr_strobe, instr, instr_pc, instr_valid,
        output mem_data, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: ADDR -> XFER -> CAPT -> OUT per instruction.
// Define INSTR_FETCH_HALT_DETECT_EN to stop fetching after accepting 16'h0000.
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset_n,
    instr_fetch_unit_if.master         bus,
    output logic [7:0]                 pc,
    output logic                       halted
);

`ifdef INSTR_FETCH_HALT_DETECT_EN
    typedef enum logic [2:0] {ST_ADDR, ST_XFER, ST_CAPT, ST_OUT, ST_HALT} state_t;
`else
    typedef enum logic [2:0] {ST_ADDR, ST_XFER, ST_CAPT, ST_OUT} state_t;
`endif

    localparam logic [7:0] RESET_PC_ALIGNED = RESET_PC & 8'hFE;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ADDR;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 8'h00;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // Redirect overrides everything, abandoning any fetch already in flight.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        if (bus.redirect) begin
            pc_d          = bus.redirect_pc & 8'hFE;
            instr_valid_d = 1'b0;
            halted_d      = 1'b0;
            state_d       = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR: state_d = ST_XFER;
                ST_XFER: state_d = ST_CAPT;
                ST_CAPT: begin
                    instr_d       = bus.mem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 8'd2;
                    state_d       = ST_OUT;
                end
                ST_OUT: begin
                    if (instr_valid_q && bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = ST_ADDR;
`ifdef INSTR_FETCH_HALT_DETECT_EN
                        if (instr_q == 16'h0000) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end
`endif
                    end
                end
`ifdef INSTR_FETCH_HALT_DETECT_EN
                ST_HALT: state_d = ST_HALT;
`endif
                default: state_d = ST_ADDR;
            endcase
        end
    end

    // Gating with reset_n keeps the strobe quiet while memory is being initialised.
    assign bus.mem_addr_strobe = (state_q == ST_ADDR) && reset_n;
    assign bus.mem_addr        = pc_q;
    assign bus.instr           = instr_q;
    assign bus.instr_pc        = instr_pc_q;
    assign bus.instr_valid     = instr_valid_q;
    assign pc                  = pc_q;

`ifdef INSTR_FETCH_HALT_DETECT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a two-stage
// instruction-memory model; a second instance checks PC wrap from 8'hFE.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] mem [256];
    logic [7:0] pc0, pc1;
    logic       halted0, halted1;

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    instr_fetch_unit #(.RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .pc(pc0), .halted(halted0)
    );

    instr_fetch_unit #(.RESET_PC(8'hFF)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .pc(pc1), .halted(halted1)
    );

    always #5 clk = ~clk;

    assign bus1.instr_ready = 1'b1;
    assign bus1.redirect    = 1'b0;
    assign bus1.redirect_pc = 8'h00;

    // Memory latches the address on the strobe edge and drives data one edge later.
    logic [7:0] lat0, lat1;
    logic       pend0, pend1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            lat0  <= 8'h00;
            lat1  <= 8'h00;
        end else begin
            pend0 <= bus0.mem_addr_strobe;
            pend1 <= bus1.mem_addr_strobe;
            if (bus0.mem_addr_strobe) lat0 <= bus0.mem_addr;
            if (bus1.mem_addr_strobe) lat1 <= bus1.mem_addr;
            if (pend0) bus0.mem_data <= {mem[lat0], mem[lat0 + 8'd1]};
            if (pend1) bus1.mem_data <= {mem[lat1], mem[lat1 + 8'd1]};
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pc0, bus0.mem_addr, bus0.mem_addr_strobe, bus0.instr, bus0.instr_pc,
             bus0.instr_valid, halted0} !== {8'h00, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got pc=%h addr=%h stb=%b instr=%h ipc=%h v=%b h=%b, want 00 00 0 0000 00 0 0",
                     pc0, bus0.mem_addr, bus0.mem_addr_strobe, bus0.instr, bus0.instr_pc, bus0.instr_valid, halted0);
        end
        n_checks++;
        if ({pc1, bus1.mem_addr_strobe} !== {8'hFE, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_pc_masked: got pc=%h stb=%b, want FE 0", pc1, bus1.mem_addr_strobe);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL first_strobe: got stb=%b addr=%h, want 1 00", bus0.mem_addr_strobe, bus0.mem_addr);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid} !== {1'b0, 8'h00, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL addr_stable: got stb=%b addr=%h v=%b, want 0 00 0",
                         bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.instr_valid, bus0.instr, bus0.instr_pc, pc0} !== {1'b1, 16'h21FE, 8'h00, 8'h02}) begin
            n_fail++;
            $display("[TB] FAIL first_instr: got v=%b instr=%h ipc=%h pc=%h, want 1 21FE 00 02",
                     bus0.instr_valid, bus0.instr, bus0.instr_pc, pc0);
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid} !== {1'b1, 8'h02, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL second_strobe: got stb=%b addr=%h v=%b, want 1 02 0",
                     bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid);
        end
    endtask

    task automatic test_stall();
        bus0.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus0.instr_valid, bus0.instr, bus0.instr_pc, bus0.mem_addr_strobe} !==
                {1'b1, 16'h1234, 8'h02, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b instr=%h ipc=%h stb=%b, want 1 1234 02 0",
                         i, bus0.instr_valid, bus0.instr, bus0.instr_pc, bus0.mem_addr_strobe);
            end
            if (i == 5) bus0.instr_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid} !== {1'b1, 8'h04, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL stall_release: got stb=%b addr=%h v=%b, want 1 04 0",
                     bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid);
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 8'h23;
        @(negedge clk);
        bus0.redirect = 1'b0;
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid} !== {1'b1, 8'h22, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL redirect_strobe: got stb=%b addr=%h v=%b, want 1 22 0",
                     bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus0.instr_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL redirect_no_old: got v=%b instr=%h, want v=0", bus0.instr_valid, bus0.instr);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.instr_valid, bus0.instr, bus0.instr_pc, pc0} !== {1'b1, 16'hC33C, 8'h22, 8'h24}) begin
            n_fail++;
            $display("[TB] FAIL redirect_instr: got v=%b instr=%h ipc=%h pc=%h, want 1 C33C 22 24",
                     bus0.instr_valid, bus0.instr, bus0.instr_pc, pc0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr} !== {1'b1, 8'h24}) begin
            n_fail++;
            $display("[TB] FAIL b2b_strobe0: got stb=%b addr=%h, want 1 24", bus0.mem_addr_strobe, bus0.mem_addr);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus0.instr_valid, bus0.instr, bus0.instr_pc} !== {1'b1, 16'h7E7F, 8'h24}) begin
            n_fail++;
            $display("[TB] FAIL b2b_instr: got v=%b instr=%h ipc=%h, want 1 7E7F 24",
                     bus0.instr_valid, bus0.instr, bus0.instr_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid} !== {1'b1, 8'h26, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL b2b_strobe1: got stb=%b addr=%h v=%b, want 1 26 0",
                     bus0.mem_addr_strobe, bus0.mem_addr, bus0.instr_valid);
        end
    endtask

    task automatic test_halt();
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 8'h3F;
        @(negedge clk);
        bus0.redirect = 1'b0;
        n_checks++;
        if ({bus0.mem_addr_strobe, bus0.mem_addr} !== {1'b1, 8'h3E}) begin
            n_fail++;
            $display("[TB] FAIL halt_fetch_addr: got stb=%b addr=%h, want 1 3E", bus0.mem_addr_strobe, bus0.mem_addr);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus0.instr_valid, bus0.instr, bus0.instr_pc} !== {1'b1, 16'h0000, 8'h3E}) begin
            n_fail++;
            $display("[TB] FAIL zero_instr: got v=%b instr=%h ipc=%h, want 1 0000 3E",
                     bus0.instr_valid, bus0.instr, bus0.instr_pc);
        end
`ifdef INSTR_FETCH_HALT_DETECT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({halted0, bus0.mem_addr_strobe, bus0.instr_valid, pc0} !== {1'b1, 1'b0, 1'b0, 8'h40}) begin
                n_fail++;
                $display("[TB] FAIL halted_idle[%0d]: got h=%b stb=%b v=%b pc=%h, want 1 0 0 40",
                         i, halted0, bus0.mem_addr_strobe, bus0.instr_valid, pc0);
            end
        end
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 8'h00;
        @(negedge clk);
        bus0.redirect = 1'b0;
        n_checks++;
        if ({halted0, bus0.mem_addr_strobe, bus0.mem_addr} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL halt_resume: got h=%b stb=%b addr=%h, want 0 1 00",
                     halted0, bus0.mem_addr_strobe, bus0.mem_addr);
        end
`else
        @(negedge clk);
        n_checks++;
        if ({halted0, bus0.mem_addr_strobe, bus0.mem_addr} !== {1'b0, 1'b1, 8'h40}) begin
            n_fail++;
            $display("[TB] FAIL zero_continues: got h=%b stb=%b addr=%h, want 0 1 40",
                     halted0, bus0.mem_addr_strobe, bus0.mem_addr);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus0.instr_valid, bus0.instr, bus0.instr_pc, halted0} !== {1'b1, 16'h1A1B, 8'h40, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL after_zero_instr: got v=%b instr=%h ipc=%h h=%b, want 1 1A1B 40 0",
                     bus0.instr_valid, bus0.instr, bus0.instr_pc, halted0);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        bus0.instr_ready = 1'b0;
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 8'h05;
        @(negedge clk);
        bus0.redirect = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus0.instr_valid, bus0.instr, bus0.instr_pc, pc0} !== {1'b1, 16'h5678, 8'h04, 8'h06}) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_out: got v=%b instr=%h ipc=%h pc=%h, want 1 5678 04 06",
                     bus0.instr_valid, bus0.instr, bus0.instr_pc, pc0);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus0.instr_valid, pc0, bus0.mem_addr, bus0.mem_addr_strobe, halted0, bus0.instr} !==
            {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got v=%b pc=%h addr=%h stb=%b h=%b instr=%h, want 0 00 00 0 0 0000",
                     bus0.instr_valid, pc0, bus0.mem_addr, bus0.mem_addr_strobe, halted0, bus0.instr);
        end
        bus0.instr_ready = 1'b1;
    endtask

    task automatic test_wrap();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus1.mem_addr_strobe, bus1.mem_addr, bus0.mem_addr_strobe, bus0.mem_addr} !==
            {1'b1, 8'hFE, 1'b1, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL wrap_first_strobe: got stb1=%b addr1=%h stb0=%b addr0=%h, want 1 FE 1 00",
                     bus1.mem_addr_strobe, bus1.mem_addr, bus0.mem_addr_strobe, bus0.mem_addr);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus1.instr_valid, bus1.instr, bus1.instr_pc, pc1} !== {1'b1, 16'hABCD, 8'hFE, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL wrap_instr: got v=%b instr=%h ipc=%h pc=%h, want 1 ABCD FE 00",
                     bus1.instr_valid, bus1.instr, bus1.instr_pc, pc1);
        end
        @(negedge clk);
        n_checks++;
        if ({bus1.mem_addr_strobe, bus1.mem_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL wrap_next_addr: got stb=%b addr=%h, want 1 00", bus1.mem_addr_strobe, bus1.mem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h00] = 8'h21; mem[8'h01] = 8'hFE;
        mem[8'h02] = 8'h12; mem[8'h03] = 8'h34;
        mem[8'h04] = 8'h56; mem[8'h05] = 8'h78;
        mem[8'h22] = 8'hC3; mem[8'h23] = 8'h3C;
        mem[8'h3E] = 8'h00; mem[8'h3F] = 8'h00;
        mem[8'hFE] = 8'hAB; mem[8'hFF] = 8'hCD;
        bus0.instr_ready = 1'b1;
        bus0.redirect    = 1'b0;
        bus0.redirect_pc = 8'h00;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
